// File: rtl/metal_det_axil_regs_if.sv
// AXI4-Lite bus bundle for the detector control port (S00_AXI).
// Parameters: ADDR_W byte address width, DATA_W data width (32 only).
// Modports:
//   master - drives AW/W/AR address, data and valid signals, plus BREADY/RREADY
//   slave  - drives the ready signals and the B/R response channels
interface metal_det_axil_regs_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/metal_det_axil_regs.sv
// AXI4-Lite responder register file for the metal detector control port.
// Holds NUM_REGS 32-bit read/write control words written by the PS master.
// Ports:
//   S_AXI_ACLK     clock, rising edge
//   S_AXI_ARESETN  asynchronous active-low reset
//   s_axi          AXI4-Lite slave modport (AW, W, B, AR, R channels)
//   reg_out        register contents, reg k at [32k+31:32k]
//   reg_wr_pulse   one-cycle pulse, bit k on the commit cycle of a write to reg k
// AW and W are buffered independently; a write commits once both buffers hold a beat.
// One outstanding write and one outstanding read; every response is OKAY.
module metal_det_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  localparam int NUM_REGS = 2 ** (C_S_AXI_ADDR_WIDTH - 2)
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESETN,
  metal_det_axil_regs_if.slave               s_axi,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]                reg_wr_pulse
);
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DW    = C_S_AXI_DATA_WIDTH;

  logic [DW-1:0]     regs_r [NUM_REGS];
  logic              ready_en_r;
  logic              aw_full_r;
  logic              w_full_r;
  logic [IDX_W-1:0]  aw_idx_r;
  logic [DW-1:0]     w_data_r;
  logic [DW/8-1:0]   w_strb_r;
  logic              bvalid_r;
  logic [NUM_REGS-1:0] wr_pulse_r;
  logic              rvalid_r;
  logic [DW-1:0]     rdata_r;

  logic              awready_s;
  logic              wready_s;
  logic              arready_s;
  logic              unused_s;

  // Byte-lane merge: each strobed lane takes the new byte, the rest keep the old byte.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_word,
                                                input logic [DW-1:0] new_word,
                                                input logic [DW/8-1:0] strb);
    logic [DW-1:0] result;
    result = old_word;
    for (int i = 0; i < DW / 8; i++) begin
      if (strb[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        result[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return result;
  endfunction

  // ready_en_r keeps every READY low while reset is asserted and for the first
  // edge after release, so the buffers are seen empty before anything is accepted.
  assign awready_s = ready_en_r && !aw_full_r && !bvalid_r;
  assign wready_s  = ready_en_r && !w_full_r  && !bvalid_r;
  assign arready_s = ready_en_r && !rvalid_r;

  assign s_axi.awready = awready_s;
  assign s_axi.wready  = wready_s;
  assign s_axi.arready = arready_s;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.rvalid  = rvalid_r;
  assign s_axi.rdata   = rdata_r;
  assign s_axi.rresp   = 2'b00;
  assign reg_wr_pulse  = wr_pulse_r;

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused_s = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Flatten the register array onto the exported bus.
  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_out[DW*k +: DW] = regs_r[k];
    end
  end

  // Write path: AW/W capture, commit into the register file, B response, write pulse.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ready_en_r <= 1'b0;
      aw_full_r  <= 1'b0;
      w_full_r   <= 1'b0;
      aw_idx_r   <= '0;
      w_data_r   <= '0;
      w_strb_r   <= '0;
      bvalid_r   <= 1'b0;
      wr_pulse_r <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_r[k] <= '0;
      end
    end else begin
      ready_en_r <= 1'b1;
      wr_pulse_r <= '0;
      if (aw_full_r && w_full_r) begin
        // Both halves present; READYs are low this cycle so nothing new arrives.
        regs_r[aw_idx_r]     <= merge_bytes(regs_r[aw_idx_r], w_data_r, w_strb_r);
        wr_pulse_r[aw_idx_r] <= 1'b1;
        bvalid_r             <= 1'b1;
        aw_full_r            <= 1'b0;
        w_full_r             <= 1'b0;
      end else begin
        if (bvalid_r && s_axi.bready) begin
          bvalid_r <= 1'b0;
        end
        if (s_axi.awvalid && awready_s) begin
          aw_idx_r  <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
          aw_full_r <= 1'b1;
        end
        if (s_axi.wvalid && wready_s) begin
          w_data_r <= s_axi.wdata;
          w_strb_r <= s_axi.wstrb;
          w_full_r <= 1'b1;
        end
      end
    end
  end

  // Read path: sample the addressed word at the AR handshake and hold it until RREADY.
  // A commit at the same edge is not yet visible, so the old value is returned.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else begin
      if (s_axi.arvalid && arready_s) begin
        rdata_r  <= regs_r[s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2]];
        rvalid_r <= 1'b1;
      end else if (rvalid_r && s_axi.rready) begin
        rvalid_r <= 1'b0;
      end else begin
        rvalid_r <= rvalid_r;
      end
    end
  end
endmodule
